// File: rtl/masked_gf_mul_pipe.sv
`default_nettype none
// ============================================================================
// Module   : masked_gf_mul_pipe
// Purpose  : First-order Boolean-masked GF(2^W) multiplier using
//            domain-oriented masking. The product of a = am^ma and
//            b = bm^mb is produced re-masked with mq, through a two-stage
//            pipeline with a valid/ready handshake on both sides.
// Ports    : clk, reset          - rising-edge clock, synchronous active-high reset
//            am, ma / bm, mb     - shares of operands a and b
//            mq                  - output mask
//            r                   - fresh randomness for the cross-domain terms
//            in_valid/in_ready   - operand handshake
//            qm                  - masked product gfmul(a,b)^mq
//            out_valid/out_ready - result handshake
// Revision : 1.0 - initial release
// ============================================================================
module masked_gf_mul_pipe #(
  parameter int         W    = 2,
  parameter logic [W:0] POLY = 3'b111
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] am,
  input  logic [W-1:0] ma,
  input  logic [W-1:0] bm,
  input  logic [W-1:0] mb,
  input  logic [W-1:0] mq,
  input  logic [W-1:0] r,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] qm,
  output logic         out_valid,
  input  logic         out_ready
);

  // Shift-and-add multiply with reduction folded into each shift, so no
  // intermediate value ever exceeds W bits.
  function automatic logic [W-1:0] gf_mul(input logic [W-1:0] x,
                                          input logic [W-1:0] y);
    logic [W-1:0] acc;
    logic [W-1:0] sh;
    acc = '0;
    sh  = x;
    for (int i = 0; i < W; i++) begin
      if (y[i]) acc = acc ^ sh;
      sh = sh[W-1] ? ((sh << 1) ^ POLY[W-1:0]) : (sh << 1);
    end
    return acc;
  endfunction

  logic [W-1:0] t0, t1, c01, c10;
  logic         v1, v2;
  logic         s2_ready;
  logic         accept;
  logic         adv1;

  assign s2_ready  = !v2 || out_ready;
  assign in_ready  = !v1 || s2_ready;
  assign accept    = in_valid && in_ready;
  assign adv1      = v1 && s2_ready;
  assign out_valid = v2;

  // Stage 1: each partial product uses at most one share of each operand.
  // The cross-domain terms are blinded by r and registered before they are
  // ever combined with anything from the other domain.
  always_ff @(posedge clk) begin
    if (reset) begin
      t0  <= '0;
      t1  <= '0;
      c01 <= '0;
      c10 <= '0;
      v1  <= 1'b0;
    end else begin
      if (accept) begin
        t0  <= gf_mul(am, bm);
        t1  <= gf_mul(ma, mb) ^ mq;
        c01 <= gf_mul(am, mb) ^ r;
        c10 <= gf_mul(ma, bm) ^ r;
        v1  <= 1'b1;
      end else if (adv1) begin
        v1  <= 1'b0;
      end
    end
  end

  // Stage 2: the domains are merged pairwise first; r cancels between c01
  // and c10 only in the final XOR.
  always_ff @(posedge clk) begin
    if (reset) begin
      qm <= '0;
      v2 <= 1'b0;
    end else begin
      if (adv1) begin
        qm <= (t0 ^ c01) ^ (t1 ^ c10);
        v2 <= 1'b1;
      end else if (out_ready) begin
        v2 <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_masked_gf_mul_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_masked_gf_mul_pipe
// Purpose  : Self-checking bench for masked_gf_mul_pipe (W=2 default
//            instance plus a W=8 AES-field instance), scoreboard based.
// Revision : 1.0 - initial release
// ============================================================================
module tb_masked_gf_mul_pipe;

  typedef struct {
    logic [1:0] exp;
    int         cyc;
  } sb_entry_t;

  logic       clk;
  logic       reset;
  logic [1:0] am, ma, bm, mb, mq, r;
  logic       in_valid, in_ready;
  logic [1:0] qm;
  logic       out_valid, out_ready;

  logic [7:0] am8, ma8, bm8, mb8, mq8, r8;
  logic       in_valid8, in_ready8;
  logic [7:0] qm8;
  logic       out_valid8, out_ready8;

  sb_entry_t  sb[$];
  int         n_vec   = 0;
  int         n_err   = 0;
  int         n_acc   = 0;
  int         cyc     = 0;
  bit         chk_lat = 0;

  masked_gf_mul_pipe #(.W(2), .POLY(3'b111)) dut (
    .clk(clk), .reset(reset),
    .am(am), .ma(ma), .bm(bm), .mb(mb), .mq(mq), .r(r),
    .in_valid(in_valid), .in_ready(in_ready),
    .qm(qm), .out_valid(out_valid), .out_ready(out_ready)
  );

  masked_gf_mul_pipe #(.W(8), .POLY(9'h11B)) dut8 (
    .clk(clk), .reset(reset),
    .am(am8), .ma(ma8), .bm(bm8), .mb(mb8), .mq(mq8), .r(r8),
    .in_valid(in_valid8), .in_ready(in_ready8),
    .qm(qm8), .out_valid(out_valid8), .out_ready(out_ready8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (observed=timeout required=finish)");
    $fatal(1, "watchdog expired");
  end

  // Reference: full carry-less product, then long division by the polynomial.
  function automatic int ref_mul(input int a, input int b, input int w, input int poly);
    int p;
    p = 0;
    for (int i = 0; i < w; i++)
      if ((b >> i) & 1) p = p ^ (a << i);
    for (int i = 2 * w - 2; i >= w; i--)
      if ((p >> i) & 1) p = p ^ (poly << (i - w));
    return p;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("miscompare on %s", tag);
    end
  endtask

  // One clock: settle, score the handshakes about to happen at the next
  // edge, then advance to just after that edge.
  task automatic tick();
    sb_entry_t e;
    #1;
    if (!reset && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("spurious_out", {31'd0, out_valid}, 32'd0);
      end else begin
        e = sb.pop_front();
        check("qm_sb", {30'd0, qm}, {30'd0, e.exp});
        if (chk_lat) check("latency", cyc - e.cyc, 32'd2);
      end
    end
    if (!reset && in_valid && in_ready) begin
      e.exp = 2'(ref_mul(int'(am ^ ma), int'(bm ^ mb), 2, 7)) ^ mq;
      e.cyc = cyc;
      sb.push_back(e);
      n_acc++;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drive(input logic [1:0] a0, a1, b0, b1, q, rr);
    am = a0; ma = a1; bm = b0; mb = b1; mq = q; r = rr;
  endtask

  logic [1:0] held_qm;

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    am8 = '0; ma8 = '0; bm8 = '0; mb8 = '0; mq8 = '0; r8 = '0;
    in_valid8 = 1'b0; out_ready8 = 1'b1;
    tick(); tick();
    reset = 1'b0;
    tick();

    // Reset state
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_qm",        {30'd0, qm},        32'd0);
    check("rst_in_ready",  {31'd0, in_ready},  32'd1);

    // Unmasked: 2*2 = x^2 = x+1 = 3
    drive(2, 0, 2, 0, 0, 0); in_valid = 1'b1;
    tick(); in_valid = 1'b0;
    check("unmasked_pending", {31'd0, out_valid}, 32'd0);
    tick();
    check("unmasked_valid", {31'd0, out_valid}, 32'd1);
    check("unmasked_qm",    {30'd0, qm},        32'd3);
    tick();

    // Masked: a=2, b=3, product 1, ^mq=2 -> 3; r must not matter
    drive(1, 3, 0, 3, 2, 1); in_valid = 1'b1;
    tick(); in_valid = 1'b0; tick();
    check("masked_r1_qm", {30'd0, qm}, 32'd3);
    tick();
    drive(1, 3, 0, 3, 2, 2); in_valid = 1'b1;
    tick(); in_valid = 1'b0; tick();
    check("masked_r2_qm", {30'd0, qm}, 32'd3);
    tick(); tick();

    // 500 back-to-back random transactions, no backpressure
    chk_lat = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 500; i++) begin
      drive(2'($urandom), 2'($urandom), 2'($urandom), 2'($urandom),
            2'($urandom), 2'($urandom));
      in_valid = 1'b1;
      if (i >= 2) check("no_bubble", {31'd0, out_valid}, 32'd1);
      tick();
    end
    in_valid = 1'b0;
    tick(); tick(); tick();
    check("stream_drained", sb.size(), 32'd0);
    chk_lat = 1'b0;

    // Backpressure: out_ready low for 4 cycles with in_valid held high
    n_acc = 0;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(2'($urandom), 2'($urandom), 2'($urandom), 2'($urandom),
            2'($urandom), 2'($urandom));
      tick();
      if (i == 1) held_qm = qm;
    end
    check("bp_accepts",   n_acc, 32'd2);
    check("bp_in_ready",  {31'd0, in_ready},  32'd0);
    check("bp_out_valid", {31'd0, out_valid}, 32'd1);
    check("bp_qm_stable", {30'd0, qm}, {30'd0, held_qm});
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    check("bp_drained", sb.size(), 32'd0);

    // Reset mid-stream with both stages full
    out_ready = 1'b0;
    in_valid  = 1'b1;
    drive(3, 0, 3, 0, 1, 0); tick();
    drive(1, 0, 2, 0, 0, 0); tick();
    in_valid = 1'b0;
    check("pre_rst_full", {31'd0, in_ready}, 32'd0);
    reset = 1'b1;
    tick();
    sb.delete();
    reset = 1'b0;
    check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_qm",        {30'd0, qm},        32'd0);
    check("midrst_in_ready",  {31'd0, in_ready},  32'd1);
    out_ready = 1'b1;
    tick();
    check("post_rst_idle", {31'd0, out_valid}, 32'd0);
    // a=3 (x+1), b=3: (x+1)^2 = x^2+1 = x -> 2, ^mq=1 -> 3
    chk_lat = 1'b1;
    drive(2, 1, 1, 2, 1, 3); in_valid = 1'b1;
    tick(); in_valid = 1'b0;
    check("post_rst_lat1", {31'd0, out_valid}, 32'd0);
    tick();
    check("post_rst_valid", {31'd0, out_valid}, 32'd1);
    check("post_rst_qm",    {30'd0, qm},        32'd3);
    tick();
    chk_lat = 1'b0;

    // W=8 AES field: 0x57 * 0x83 = 0xC1, ^0xA5 = 0x64
    check("w8_rst_valid", {31'd0, out_valid8}, 32'd0);
    am8 = 8'h5A; ma8 = 8'h0D; bm8 = 8'hFF; mb8 = 8'h7C; mq8 = 8'hA5; r8 = 8'h3C;
    in_valid8 = 1'b1;
    tick(); in_valid8 = 1'b0;
    tick();
    check("w8_valid", {31'd0, out_valid8}, 32'd1);
    check("w8_qm",    {24'd0, qm8},        32'h64);
    tick();
    check("w8_bubble", {31'd0, out_valid8}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/masked_gf_mul_pipe.md
Name: masked_gf_mul_pipe

Overview:
- Parametrised successor to the 2-bit `maskmul` block.
- First-order Boolean-masked GF(2^W) multiplier using domain-oriented masking (DOM) with a fresh-randomness input.
- Output is the product re-masked with `mq`. Two-stage pipeline with valid/ready handshake on both sides.
- Sits in the masked datapath between share-generating logic and downstream masked consumers. `glsim`/SDF benches run it gate-level.

Parameters:
- W, 2, operand/share width in bits; legal range 2..16.
- POLY, 3'b111, irreducible reduction polynomial, W+1 bits, POLY[W] must be 1. Default is x^2+x+1. Use 9'h11B for W=8.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- am  input  W  share 0 of operand a
- ma  input  W  share 1 (mask) of operand a; a = am^ma
- bm  input  W  share 0 of operand b
- mb  input  W  share 1 (mask) of operand b; b = bm^mb
- mq  input  W  output mask
- r  input  W  fresh randomness for the cross-domain terms
- in_valid  input  1  operand set valid
- in_ready  output  1  block accepts operands this cycle
- qm  output  W  masked product: gfmul(a,b)^mq
- out_valid  output  1  qm valid
- out_ready  input  1  consumer accepts qm

Behaviour:
- Function: gfmul is polynomial multiplication over GF(2) reduced mod POLY. All arithmetic is XOR/AND; no carries.
- Accept rule: operands are captured when in_valid && in_ready. am/ma/bm/mb/mq/r are sampled only on acceptance.
- Stage 1 registers, loaded on acceptance, with v1 <= 1:
  - t0 = gfmul(am,bm)
  - t1 = gfmul(ma,mb)^mq
  - c01 = gfmul(am,mb)^r
  - c10 = gfmul(ma,bm)^r
- Share domains: cross terms are registered before any combination. a and b must never appear unmasked in any register or in logic between stages.
- Stage 2 register: qm <= (t0^c01)^(t1^c10). Loaded when v1 && s2_ready, with v2 <= 1.
- Handshake equations:
  - s2_ready = !v2 || out_ready
  - in_ready = !v1 || s2_ready. This is combinational from out_ready, which is permitted.
  - out_valid = v2.
- Bubble handling:
  - v1 clears when stage 1 advances with no new acceptance.
  - v2 clears on out_ready with no stage-1 advance.
- Latency: 2 cycles from acceptance to out_valid with no backpressure. Throughput 1 result/cycle.
- Backpressure: with out_ready=0 the block holds at most 2 results. in_ready falls the cycle both stages are full. qm and out_valid stay stable until out_ready.
- Simultaneous events: if out_ready=1 while both stages are full, all of the following happen in the same cycle:
  - stage 2 drains and reloads from stage 1;
  - stage 1 accepts new operands;
  - no bubble is inserted.
- Reset (synchronous, any cycle, including mid-stream):
  - v1=0, v2=0, out_valid=0, qm=0, all stage-1 data registers 0;
  - in_ready=1 in the cycle after reset deasserts;
  - in-flight results are discarded.
- qm holds its last value while out_valid=0. Consumers must qualify with out_valid.

Test Plan:
- W=2, unmasked: am=2,ma=0,bm=2,mb=0,mq=0,r=0 -> qm=3 two cycles later, out_valid=1.
- W=2, masked: am=1,ma=3,bm=0,mb=3,mq=2,r=1 -> a=2,b=3, product 1, qm=3. Repeat with r=2 -> same qm, showing r has no functional effect.
- W=2, exhaustive random: 500 back-to-back transactions, out_ready=1 -> qm matches the reference model each cycle, no bubbles, latency 2.
- Backpressure: out_ready=0 for 4 cycles while in_valid=1 -> in_ready drops after 2 acceptances. Release out_ready -> results emerge in order with none lost or duplicated.
- Reset mid-stream: assert reset with v1=v2=1 -> next cycle out_valid=0, qm=0, in_ready=1. First post-reset result appears 2 cycles after acceptance.
- W=8, POLY=9'h11B: a=0x57 (am=0x5A,ma=0x0D), b=0x83 (bm=0xFF,mb=0x7C), mq=0xA5 -> qm=0xC1^0xA5=0x64.
